// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: control-word field positions,
// the fetch/execute phase type and the control-ROM address packing helper.
package cpu_pkg;

  localparam int OPC_W       = 4;
  localparam int CW_W        = 13;
  localparam int CW_INC_PC   = 12;
  localparam int CW_LOAD_PC  = 11;
  localparam int CW_FLAGS_WE = 9;

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_t;

  // Control-ROM address layout: opcode, carry, zero, phase (MSB to LSB).
  function automatic logic [6:0] make_decode_addr(input logic [OPC_W-1:0] opc,
                                                  input logic             c,
                                                  input logic             z,
                                                  input phase_t           ph);
    return {opc, c, z, ph};
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_unit.sv
// Program counter register. Priority on an advancing cycle is
// load > increment > hold; the increment wraps modulo 2^PC_W.
module pc_unit #(
  parameter int PC_W = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            adv_i,
  input  logic            load_i,
  input  logic            inc_i,
  input  logic [PC_W-1:0] load_val_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Next PC: a load target beats an increment; nothing moves without adv.
  always_comb begin
    pc_d = pc_q;
    if (adv_i && load_i) begin
      pc_d = load_val_i;
    end else if (adv_i && inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register with synchronous reset to address zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer for the 4-bit CPU. Holds IR, flags, phase and the
// retired-instruction counter, drives the control-ROM address and steers the
// PC unit from the control word returned by the ROM.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W   = 12,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] prog_byte,
  input  logic [CW_W-1:0]   ctrl_word,
  input  logic              c_in,
  input  logic              z_in,
  output logic [PC_W-1:0]   pc,
  output logic [6:0]        decode_addr,
  output logic              phase,
  output logic [3:0]        operand,
  output logic              c_flag,
  output logic              z_flag,
  output logic [CNT_W-1:0]  instr_count
);

  logic [DATA_W-1:0] ir_q,  ir_d;
  phase_t            phase_q, phase_d;
  logic              c_q,   c_d;
  logic              z_q,   z_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              adv_s;
  logic [PC_W-1:0]   load_target_s;
  logic              unused_ctrl_bits;

  assign adv_s = enable & mem_ready;

  // Jump target: low nibble of the opcode byte followed by the second byte.
  assign load_target_s = PC_W'({ir_q[3:0], prog_byte});

  // Control-word bits outside this block's fields are intentionally ignored.
  assign unused_ctrl_bits = ^{ctrl_word[10], ctrl_word[8:0]};

  pc_unit #(
    .PC_W (PC_W)
  ) u_pc_unit (
    .clk        (clk),
    .reset      (reset),
    .adv_i      (adv_s),
    .load_i     (ctrl_word[CW_LOAD_PC]),
    .inc_i      (ctrl_word[CW_INC_PC]),
    .load_val_i (load_target_s),
    .pc_o       (pc)
  );

  // Phase sequencing: fetch latches IR, execute updates flags and retires.
  always_comb begin
    ir_d    = ir_q;
    phase_d = phase_q;
    c_d     = c_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    if (adv_s) begin
      if (phase_q == PH_FETCH) begin
        ir_d    = prog_byte;
        phase_d = PH_EXEC;
      end else begin
        phase_d = PH_FETCH;
        cnt_d   = cnt_q + CNT_W'(1);
        if (ctrl_word[CW_FLAGS_WE]) begin
          c_d = c_in;
          z_d = z_in;
        end else begin
          c_d = c_q;
          z_d = z_q;
        end
      end
    end else begin
      phase_d = phase_q;
      ir_d    = ir_q;
    end
  end

  // Sequencer state registers; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q    <= '0;
      phase_q <= PH_FETCH;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ir_q    <= ir_d;
      phase_q <= phase_d;
      c_q     <= c_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
    end
  end

  assign decode_addr = make_decode_addr(ir_q[DATA_W-1 -: OPC_W], c_q, z_q, phase_q);
  assign phase       = phase_q;
  assign operand     = ir_q[3:0];
  assign c_flag      = c_q;
  assign z_flag      = z_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized cycles, all compared against a behavioural model of the sequencer.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        mem_ready;
  logic [7:0]  prog_byte;
  logic [12:0] ctrl_word;
  logic        c_in;
  logic        z_in;
  logic [11:0] pc;
  logic [6:0]  decode_addr;
  logic        phase;
  logic [3:0]  operand;
  logic        c_flag;
  logic        z_flag;
  logic [15:0] instr_count;

  int tests_run;
  int tests_failed;

  // Behavioural model state
  int       m_pc;
  int       m_ir;
  int       m_phase;
  int       m_c;
  int       m_z;
  int       m_cnt;

  fetch_sequencer #(
    .PC_W   (12),
    .DATA_W (8),
    .CNT_W  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mem_ready   (mem_ready),
    .prog_byte   (prog_byte),
    .ctrl_word   (ctrl_word),
    .c_in        (c_in),
    .z_in        (z_in),
    .pc          (pc),
    .decode_addr (decode_addr),
    .phase       (phase),
    .operand     (operand),
    .c_flag      (c_flag),
    .z_flag      (z_flag),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the architectural rules, using the inputs present before the edge.
  task automatic model_update();
    int new_pc;
    if (reset) begin
      m_pc = 0; m_ir = 0; m_phase = 0; m_c = 0; m_z = 0; m_cnt = 0;
    end else if (enable && mem_ready) begin
      if (ctrl_word[11])      new_pc = (m_ir % 16) * 256 + int'(prog_byte);
      else if (ctrl_word[12]) new_pc = (m_pc + 1) % 4096;
      else                    new_pc = m_pc;
      if (m_phase == 0) begin
        m_ir    = int'(prog_byte);
        m_phase = 1;
      end else begin
        if (ctrl_word[9]) begin
          m_c = int'(c_in);
          m_z = int'(z_in);
        end
        m_phase = 0;
        m_cnt   = (m_cnt + 1) % 65536;
      end
      m_pc = new_pc;
    end
  endtask

  task automatic check_all();
    int exp_dec;
    exp_dec = (m_ir / 16) * 8 + m_c * 4 + m_z * 2 + m_phase;
    chk("pc",          32'(pc),          m_pc);
    chk("operand",     32'(operand),     m_ir % 16);
    chk("decode_addr", 32'(decode_addr), exp_dec);
    chk("phase",       32'(phase),       m_phase);
    chk("c_flag",      32'(c_flag),      m_c);
    chk("z_flag",      32'(z_flag),      m_z);
    chk("instr_count", 32'(instr_count), m_cnt);
  endtask

  task automatic cyc(input logic r, input logic en, input logic rdy, input logic [7:0] pb,
                     input logic [12:0] cw, input logic ci, input logic zi);
    reset = r; enable = en; mem_ready = rdy; prog_byte = pb; ctrl_word = cw;
    c_in = ci; z_in = zi;
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    m_pc = 0; m_ir = 0; m_phase = 0; m_c = 0; m_z = 0; m_cnt = 0;
    reset = 1'b1; enable = 1'b0; mem_ready = 1'b0; prog_byte = 8'h00;
    ctrl_word = 13'h0000; c_in = 1'b0; z_in = 1'b0;

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 13'h0000, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'hFF, 13'h1FFF, 1'b1, 1'b1);
    chk("dir_reset_pc", 32'(pc), 32'h0);
    chk("dir_reset_cnt", 32'(instr_count), 32'h0);

    // First fetch
    cyc(1'b0, 1'b1, 1'b1, 8'h35, 13'h1008, 1'b0, 1'b0);
    chk("dir_fetch_pc", 32'(pc), 32'h1);
    chk("dir_fetch_dec", 32'(decode_addr), 32'h19);
    chk("dir_fetch_op", 32'(operand), 32'h5);
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 13'h1008, 1'b0, 1'b0);

    // Jump: ir=0x4A, second byte 0xBC
    cyc(1'b0, 1'b1, 1'b1, 8'h4A, 13'h1008, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'hBC, 13'h0808, 1'b0, 1'b0);
    chk("dir_jump_pc", 32'(pc), 32'hABC);
    chk("dir_jump_phase", 32'(phase), 32'h0);
    chk("dir_jump_cnt", 32'(instr_count), 32'h2);

    // ALU op updates flags, then a fetch with bit9 must not
    cyc(1'b0, 1'b1, 1'b1, 8'h7E, 13'h1008, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 13'h1260, 1'b1, 1'b0);
    chk("dir_alu_c", 32'(c_flag), 32'h1);
    chk("dir_alu_z", 32'(z_flag), 32'h0);
    chk("dir_alu_pc", 32'(pc), 32'hABE);
    cyc(1'b0, 1'b1, 1'b1, 8'h63, 13'h1208, 1'b0, 1'b1);
    chk("dir_fetchwe_c", 32'(c_flag), 32'h1);
    chk("dir_fetchwe_z", 32'(z_flag), 32'h0);

    // Three stalled execute cycles, then release
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'hA5, 13'h1A00, 1'b0, 1'b1);
      chk("dir_stall_pc", 32'(pc), 32'hABF);
      chk("dir_stall_dec", 32'(decode_addr), 32'h35);
    end
    cyc(1'b0, 1'b1, 1'b1, 8'hA5, 13'h1200, 1'b0, 1'b1);
    chk("dir_release_pc", 32'(pc), 32'hAC0);
    chk("dir_release_dec", 32'(decode_addr), 32'h32);

    // PC wrap and load/inc priority
    cyc(1'b0, 1'b1, 1'b1, 8'h2F, 13'h1008, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'hFF, 13'h0800, 1'b0, 1'b0);
    chk("dir_pre_wrap_pc", 32'(pc), 32'hFFF);
    cyc(1'b0, 1'b1, 1'b1, 8'h57, 13'h1008, 1'b0, 1'b0);
    chk("dir_wrap_pc", 32'(pc), 32'h000);
    cyc(1'b0, 1'b1, 1'b1, 8'h9A, 13'h1800, 1'b0, 1'b0);
    chk("dir_both_pc", 32'(pc), 32'h79A);
    chk("dir_both_cnt", 32'(instr_count), 32'h6);

    // Enable dropped mid-instruction
    cyc(1'b0, 1'b1, 1'b1, 8'hC3, 13'h1008, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h11, 13'h1A00, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h22, 13'h0800, 1'b1, 1'b1);
    chk("dir_disable_phase", 32'(phase), 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 13'h1000, 1'b0, 1'b0);
    chk("dir_resume_phase", 32'(phase), 32'h0);

    // Reset during execute with flags_we
    cyc(1'b0, 1'b1, 1'b1, 8'hE1, 13'h1008, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h44, 13'h1A00, 1'b1, 1'b1);
    chk("dir_rst_exec_pc", 32'(pc), 32'h0);
    chk("dir_rst_exec_phase", 32'(phase), 32'h0);
    chk("dir_rst_exec_c", 32'(c_flag), 32'h0);
    chk("dir_rst_exec_cnt", 32'(instr_count), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 99) < 85),
          ($urandom_range(0, 99) < 75),
          8'($urandom),
          13'($urandom),
          1'($urandom),
          1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
